// File: rtl/boot_sequencer.sv
// Reset/boot sequencer for the CADR core: debounces the front-panel button and
// steps the CPU through reset, boot strobe and the debug-controlled run/halt state.
module boot_sequencer #(
    parameter int PRESCALE_W   = 8,
    parameter int DEBOUNCE_LEN = 10,
    parameter int RESET_LEN    = 240,
    parameter int BOOT_LEN     = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       button,
    input  logic       halt_req,
    input  logic       run_req,
    output logic       cpu_reset,
    output logic       cpu_boot,
    output logic       cpu_halt,
    output logic [1:0] state,
    output logic [7:0] reset_count
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_BOOT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [7:0]            RESET_LAST   = 8'(RESET_LEN - 1);
    localparam logic [7:0]            BOOT_LAST    = 8'(BOOT_LEN - 1);
    localparam logic [PRESCALE_W-1:0] PRESCALE_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0]   prescale_r;
    logic [1:0]              sync_r;
    logic [DEBOUNCE_LEN-1:0] shift_r;
    logic [DEBOUNCE_LEN-1:0] shift_next_s;
    logic                    level_r;
    logic                    level_d_r;
    logic                    level_next_s;
    logic                    tick_s;
    logic                    press_s;

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] seq_cnt_r;
    logic [7:0] seq_cnt_next_s;
    logic [7:0] reset_count_r;
    logic [7:0] reset_count_next_s;
    logic       cpu_reset_r;
    logic       cpu_boot_r;
    logic       cpu_halt_r;
    logic       cpu_reset_next_s;
    logic       cpu_boot_next_s;
    logic       cpu_halt_next_s;

    assign tick_s  = &prescale_r;
    assign press_s = level_r & ~level_d_r;

    // Sample shifting and hysteresis level decision
    always_comb begin
        shift_next_s = shift_r;
        level_next_s = level_r;
        if (tick_s) begin
            shift_next_s = {shift_r[DEBOUNCE_LEN-2:0], sync_r[1]};
        end else begin
            shift_next_s = shift_r;
        end
        if (&shift_next_s) begin
            level_next_s = 1'b1;
        end else if (~|shift_next_s) begin
            level_next_s = 1'b0;
        end else begin
            level_next_s = level_r;
        end
    end

    // Prescaler, button synchronizer and debounce registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_r <= {PRESCALE_W{1'b0}};
            sync_r     <= 2'b00;
            shift_r    <= {DEBOUNCE_LEN{1'b0}};
            level_r    <= 1'b0;
            level_d_r  <= 1'b0;
        end else begin
            prescale_r <= prescale_r + PRESCALE_ONE;
            sync_r     <= {sync_r[0], button};
            shift_r    <= shift_next_s;
            level_r    <= level_next_s;
            level_d_r  <= level_r;
        end
    end

    // Next state, sequence counter and press counter
    always_comb begin
        state_next_s       = state_r;
        seq_cnt_next_s     = 8'd0;
        reset_count_next_s = reset_count_r;
        case (state_r)
            ST_RESET: begin
                if (level_r) begin
                    seq_cnt_next_s = 8'd0;
                end else if (seq_cnt_r == RESET_LAST) begin
                    state_next_s   = ST_BOOT;
                    seq_cnt_next_s = 8'd0;
                end else begin
                    seq_cnt_next_s = seq_cnt_r + 8'd1;
                end
            end
            ST_BOOT: begin
                if (seq_cnt_r == BOOT_LAST) begin
                    state_next_s   = ST_RUN;
                    seq_cnt_next_s = 8'd0;
                end else begin
                    seq_cnt_next_s = seq_cnt_r + 8'd1;
                end
            end
            ST_RUN, ST_HALT: begin
                if (press_s) begin
                    state_next_s = ST_RESET;
                    if (reset_count_r != 8'hFF) begin
                        reset_count_next_s = reset_count_r + 8'd1;
                    end else begin
                        reset_count_next_s = reset_count_r;
                    end
                end else if (halt_req) begin
                    state_next_s = ST_HALT;
                end else if (run_req) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s   = ST_RESET;
                seq_cnt_next_s = 8'd0;
            end
        endcase
    end

    // Output levels decoded from the state being entered so they register with it
    always_comb begin
        cpu_reset_next_s = 1'b0;
        cpu_boot_next_s  = 1'b0;
        cpu_halt_next_s  = 1'b0;
        case (state_next_s)
            ST_RESET: cpu_reset_next_s = 1'b1;
            ST_BOOT:  cpu_boot_next_s  = 1'b1;
            ST_RUN:   cpu_halt_next_s  = 1'b0;
            ST_HALT:  cpu_halt_next_s  = 1'b1;
            default:  cpu_reset_next_s = 1'b1;
        endcase
    end

    // State, counters and CPU control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_RESET;
            seq_cnt_r     <= 8'd0;
            reset_count_r <= 8'd0;
            cpu_reset_r   <= 1'b1;
            cpu_boot_r    <= 1'b0;
            cpu_halt_r    <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            seq_cnt_r     <= seq_cnt_next_s;
            reset_count_r <= reset_count_next_s;
            cpu_reset_r   <= cpu_reset_next_s;
            cpu_boot_r    <= cpu_boot_next_s;
            cpu_halt_r    <= cpu_halt_next_s;
        end
    end

    assign state       = state_r;
    assign reset_count = reset_count_r;
    assign cpu_reset   = cpu_reset_r;
    assign cpu_boot    = cpu_boot_r;
    assign cpu_halt    = cpu_halt_r;

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: timeline model for power-up/boot,
// run/halt request model, debounce latency windows and reset_count saturation.
module tb_boot_sequencer;

    localparam int RL = 240;
    localparam int BL = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       button = 1'b0;
    logic       halt_req = 1'b0;
    logic       run_req = 1'b0;
    logic       cpu_reset, cpu_boot, cpu_halt;
    logic [1:0] state;
    logic [7:0] reset_count;

    logic       button2 = 1'b0;
    logic       cpu_reset2, cpu_boot2, cpu_halt2;
    logic [1:0] state2;
    logic [7:0] reset_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    boot_sequencer #(.PRESCALE_W(2), .DEBOUNCE_LEN(10), .RESET_LEN(RL), .BOOT_LEN(BL)) dut (
        .clk(clk), .reset_n(reset_n), .button(button), .halt_req(halt_req), .run_req(run_req),
        .cpu_reset(cpu_reset), .cpu_boot(cpu_boot), .cpu_halt(cpu_halt),
        .state(state), .reset_count(reset_count)
    );

    // Small, fast instance used for the 300-press saturation run
    boot_sequencer #(.PRESCALE_W(1), .DEBOUNCE_LEN(2), .RESET_LEN(4), .BOOT_LEN(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .button(button2), .halt_req(1'b0), .run_req(1'b0),
        .cpu_reset(cpu_reset2), .cpu_boot(cpu_boot2), .cpu_halt(cpu_halt2),
        .state(state2), .reset_count(reset_count2)
    );

    // Expected {state, cpu_reset, cpu_boot, cpu_halt} k clock edges after reset release
    function automatic logic [4:0] exp_seq(input int k);
        if (k < RL)           return 5'b00_100;
        else if (k < RL + BL) return 5'b01_010;
        else                  return 5'b10_000;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({state, cpu_reset, cpu_boot, cpu_halt} !== 5'b00_100) begin
            errors++;
            $display("FAIL reset_outputs got %b expected %b", {state, cpu_reset, cpu_boot, cpu_halt}, 5'b00_100);
        end
        checks++;
        if (reset_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count_init got %0d expected 0", reset_count);
        end
    endtask

    task automatic test_power_up();
        reset_n = 1'b1;
        for (int k = 0; k <= RL + BL + 2; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if ({state, cpu_reset, cpu_boot, cpu_halt} !== exp_seq(k)) begin
                errors++;
                $display("FAIL power_up k=%0d got %b expected %b", k, {state, cpu_reset, cpu_boot, cpu_halt}, exp_seq(k));
            end
        end
    endtask

    task automatic test_bounce();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i % 20 == 0) begin
                checks++;
                if (state !== 2'd2 || cpu_reset !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce i=%0d state %0d cpu_reset %b expected 2/0", i, state, cpu_reset);
                end
            end
            if (i % 3 == 0) button = ~button;
        end
        button = 1'b0;
        checks++;
        if (reset_count !== 8'd0) begin
            errors++;
            $display("FAIL bounce_count got %0d expected 0", reset_count);
        end
        repeat (80) @(negedge clk);
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL bounce_settle state %0d expected 2", state);
        end
    endtask

    task automatic test_halt_run();
        int m;
        logic h, r;
        m = 2;
        for (int i = 0; i < 204; i++) begin
            @(negedge clk);
            checks++;
            if ({state, cpu_reset, cpu_boot, cpu_halt} !== {2'(m), 1'b0, 1'b0, (m == 3)}) begin
                errors++;
                $display("FAIL halt_run i=%0d got %b expected state %0d", i, {state, cpu_reset, cpu_boot, cpu_halt}, m);
            end
            case (i)
                0: begin h = 1'b1; r = 1'b0; end
                1: begin h = 1'b0; r = 1'b1; end
                2: begin h = 1'b1; r = 1'b1; end
                3: begin h = 1'b0; r = 1'b1; end
                default: begin
                    h = ($urandom_range(0, 3) == 0);
                    r = ($urandom_range(0, 2) == 0);
                end
            endcase
            if (i >= 202) begin h = 1'b0; r = 1'b1; end
            halt_req = h;
            run_req  = r;
            if (h) m = 3;
            else if (r) m = 2;
        end
        @(negedge clk);
        halt_req = 1'b0;
        run_req  = 1'b0;
        checks++;
        if (state !== 2'd2 || cpu_halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_run_end state %0d cpu_halt %b expected 2/0", state, cpu_halt);
        end
    endtask

    task automatic test_clean_press();
        int lat, d;
        button = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (cpu_reset !== 1'b1 && lat < 100);
        checks++;
        if (lat < 40 || lat > 43) begin
            errors++;
            $display("FAIL press_latency got %0d expected 40..43", lat);
        end
        checks++;
        if (reset_count !== 8'd1 || state !== 2'd0) begin
            errors++;
            $display("FAIL press_count count %0d state %0d expected 1/0", reset_count, state);
        end
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            checks++;
            if (state !== 2'd0 || cpu_reset !== 1'b1) begin
                errors++;
                $display("FAIL press_hold cycle %0d state %0d cpu_reset %b", lat, state, cpu_reset);
            end
        end
        button = 1'b0;
        d = 0;
        do begin @(negedge clk); d++; end while (cpu_reset === 1'b1 && d < 400);
        checks++;
        if (d < RL + 39 || d > RL + 42) begin
            errors++;
            $display("FAIL release_delay got %0d expected %0d..%0d", d, RL + 39, RL + 42);
        end
        for (int j = 0; j < BL; j++) begin
            if (j > 0) @(negedge clk);
            checks++;
            if ({state, cpu_reset, cpu_boot, cpu_halt} !== 5'b01_010) begin
                errors++;
                $display("FAIL press_boot j=%0d got %b expected 01010", j, {state, cpu_reset, cpu_boot, cpu_halt});
            end
        end
        @(negedge clk);
        checks++;
        if ({state, cpu_reset, cpu_boot, cpu_halt} !== 5'b10_000) begin
            errors++;
            $display("FAIL press_run got %b expected 10000", {state, cpu_reset, cpu_boot, cpu_halt});
        end
    endtask

    task automatic test_press_in_halt();
        int lat;
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        checks++;
        if (state !== 2'd3 || cpu_halt !== 1'b1) begin
            errors++;
            $display("FAIL halt_enter state %0d cpu_halt %b expected 3/1", state, cpu_halt);
        end
        button = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (state === 2'd3 && lat < 100);
        checks++;
        if (lat < 40 || lat > 43) begin
            errors++;
            $display("FAIL halt_press_latency got %0d expected 40..43", lat);
        end
        checks++;
        if ({state, cpu_reset, cpu_boot, cpu_halt} !== 5'b00_100 || reset_count !== 8'd2) begin
            errors++;
            $display("FAIL halt_press got %b count %0d expected 00100 count 2", {state, cpu_reset, cpu_boot, cpu_halt}, reset_count);
        end
        repeat (5) @(negedge clk);
        button = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (state !== 2'd2 && lat < 500);
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL halt_press_recover state %0d expected 2", state);
        end
    endtask

    task automatic test_reset_mid_boot();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k <= RL + 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if ({state, cpu_reset, cpu_boot, cpu_halt} !== exp_seq(k)) begin
                errors++;
                $display("FAIL mid_boot_pre k=%0d got %b expected %b", k, {state, cpu_reset, cpu_boot, cpu_halt}, exp_seq(k));
            end
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({state, cpu_reset, cpu_boot, cpu_halt} !== 5'b00_100 || reset_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_boot_abort got %b count %0d expected 00100 count 0", {state, cpu_reset, cpu_boot, cpu_halt}, reset_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k <= RL + BL + 3; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if ({state, cpu_reset, cpu_boot, cpu_halt} !== exp_seq(k)) begin
                errors++;
                $display("FAIL mid_boot_rerun k=%0d got %b expected %b", k, {state, cpu_reset, cpu_boot, cpu_halt}, exp_seq(k));
            end
            if (k >= RL && k < RL + BL) begin
                halt_req = ($urandom_range(0, 1) == 1);
                run_req  = ($urandom_range(0, 1) == 1);
            end else begin
                halt_req = 1'b0;
                run_req  = 1'b0;
            end
        end
    endtask

    task automatic test_saturation();
        int n, w, expc;
        bit timed_out;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        timed_out = 1'b0;
        for (n = 1; n <= 300 && !timed_out; n++) begin
            button2 = 1'b1;
            w = 0;
            do begin @(negedge clk); w++; end while (state2 !== 2'd0 && w < 60);
            button2 = 1'b0;
            do begin @(negedge clk); w++; end while (state2 !== 2'd2 && w < 160);
            expc = (n > 255) ? 255 : n;
            checks++;
            if (state2 !== 2'd2 || reset_count2 !== 8'(expc)) begin
                errors++;
                timed_out = 1'b1;
                $display("FAIL saturation press %0d count %0d state %0d expected count %0d", n, reset_count2, state2, expc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_bounce();
        test_halt_run();
        test_clean_press();
        test_press_in_halt();
        test_reset_mid_boot();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
# boot_sequencer

Reset/boot sequencer for the CADR core. It debounces the front-panel reset button and, after power-up or a button press, drives the CPU through a fixed reset interval and a boot-strobe interval. It then holds the run/halt state requested by the debug interface. It sits between the board clock/reset and the processor's reset, boot and halt inputs.

## Interface
Parameters:
- PRESCALE_W, 8: width of the free-running prescaler; one debounce sample tick every 2^PRESCALE_W clk cycles.
- DEBOUNCE_LEN, 10: number of consecutive equal samples needed to change the debounced level (≥2).
- RESET_LEN, 240: clk cycles cpu_reset stays asserted after entering RESET (1..255).
- BOOT_LEN, 10: clk cycles cpu_boot stays asserted (1..255).

Ports:
- clk  in  1  system clock; all logic is in this single domain.
- reset_n  in  1  asynchronous, active-low reset.
- button  in  1  raw, asynchronous, bouncing reset button; high = pressed.
- halt_req  in  1  single-cycle request to halt the CPU.
- run_req  in  1  single-cycle request to resume the CPU.
- cpu_reset  out  1  reset to the processor.
- cpu_boot  out  1  boot strobe to the processor.
- cpu_halt  out  1  halt to the processor.
- state  out  2  current state: RESET=0, BOOT=1, RUN=2, HALT=3.
- reset_count  out  8  number of button-initiated resets; saturates at 255.

## Operation
- **Reset values (reset_n low, asynchronous):**
  - state = RESET, cpu_reset = 1, cpu_boot = 0, cpu_halt = 0.
  - Sequence counter, prescaler, synchronizer, sample shift register, debounced level and reset_count all clear to 0.
- **Synchronizer:** button passes through a 2-flop synchronizer.
- **Debounce:**
  - The prescaler increments every cycle and wraps. A tick occurs in the cycle the prescaler is all-ones.
  - On each tick, the synchronized button shifts into a DEBOUNCE_LEN-bit shift register.
  - The debounced level is set when the register is all ones and cleared when it is all zeros (hysteresis); otherwise it holds.
  - A press event is the 0→1 transition of the debounced level.
- **State machine** (outputs are registered and change on the same edge as state):
  - **RESET:** cpu_reset = 1.
    - The sequence counter is held at 0 while the debounced level is 1; otherwise it increments.
    - When counter == RESET_LEN-1 and the level is 0, go to BOOT.
  - **BOOT:** cpu_reset = 0, cpu_boot = 1.
    - After BOOT_LEN cycles, go to RUN.
    - halt_req, run_req and press events are ignored.
  - **RUN:** all CPU outputs are 0.
    - A press event goes to RESET.
    - Otherwise halt_req goes to HALT.
  - **HALT:** cpu_halt = 1.
    - A press event goes to RESET.
    - Otherwise run_req goes to RUN.
- **Priority:** press event > halt_req > run_req. halt_req and run_req together in RUN → HALT. run_req in RUN and halt_req in HALT have no effect.
- **Counter behaviour:**
  - The sequence counter is 8 bits and clears on every state entry.
  - reset_count increments on each press event accepted in RUN or HALT and saturates at 255.

## Timing
- From reset_n rising:
  - cpu_reset stays 1 for exactly RESET_LEN clk edges (button released).
  - cpu_boot is then 1 for exactly BOOT_LEN cycles, with cpu_reset already 0 in the first BOOT cycle.
  - RUN follows.
- Press latency: the button must be stable for DEBOUNCE_LEN ticks. From the last bounce to the level change takes 2 cycles of synchronizer plus up to DEBOUNCE_LEN·2^PRESCALE_W cycles. cpu_reset rises on the edge after the level rises.
- Holding the button extends RESET indefinitely. The RESET_LEN count starts in the cycle the debounced level falls.
- halt_req/run_req take effect on the next edge: cpu_halt changes one cycle after the request.
- Asserting reset_n mid-sequence aborts immediately. All outputs return to their reset values, and the full RESET_LEN + BOOT_LEN sequence reruns after release.
- Wrap-around: the prescaler wraps freely. The sequence counter never exceeds 254.

## Test plan
- Power-up (defaults, button = 0): release reset_n → cpu_reset = 1 for 240 cycles, cpu_boot = 1 for the next 10 cycles, then state = 2 with all CPU outputs 0.
- Bounce rejection (PRESCALE_W = 2, DEBOUNCE_LEN = 10): toggle button every 3 cycles for 400 cycles while in RUN → state stays 2, reset_count = 0, cpu_reset = 0.
- Clean press (PRESCALE_W = 2): hold button high for 200 cycles, then release → cpu_reset rises ≤43 cycles after press, stays high while held and for 240 cycles after the debounced level falls, then boot sequence; reset_count = 1.
- Halt/run:
  - halt_req pulse in RUN → cpu_halt = 1 next cycle.
  - run_req → cpu_halt = 0 next cycle.
  - halt_req and run_req together in RUN → state = 3.
  - halt_req during BOOT → ignored, RUN reached on schedule.
- Press in HALT → state = 0, cpu_halt = 0, cpu_reset = 1 next cycle. Drive 300 presses → reset_count saturates at 255.
- reset_n pulsed low in cycle 5 of BOOT → cpu_boot = 0 and cpu_reset = 1 immediately, reset_count = 0; a full 240 + 10 cycle sequence follows release.
